weight_load_ctrl: RTL and testbench
===================================

Name: weight_load_ctrl

Overview:
Sequences the 5x5 kernel weight ROM (the weight_total_5x5_kernel block memory: clka/ena/addra/douta, 16-bit data, 12-bit address) for the convolution engine. On a start request with a kernel index, it:
- computes the kernel base address,
- issues 25 consecutive ROM reads,
- absorbs the ROM read latency,
- captures the returned taps into a flat 400-bit weight register.

The result is held stable for the MAC array, with a done pulse and a valid level.

Parameters:
DATA_WIDTH, 16, weight word width (matches ROM douta)
ADDR_WIDTH, 12, ROM address width
KSIZE, 5, kernel side; KTAPS = KSIZE*KSIZE = 25
NUM_KERNELS, 163, number of kernels stored; valid kernel_idx range is 0..NUM_KERNELS-1
BASE_ADDR, 0, ROM address of tap 0 of kernel 0
ROM_LAT, 1, ROM read latency in cycles (range 1..3)

Ports:
clk  in  1  system clock; also drives ROM clka
rst_n  in  1  asynchronous active-low reset
start  in  1  load request; sampled only in IDLE
kernel_idx  in  8  kernel to load; sampled with start
busy  out  1  high while a load is in progress (ISSUE/DRAIN)
done  out  1  one-cycle pulse when all 25 taps are captured
err  out  1  one-cycle pulse when kernel_idx >= NUM_KERNELS
weights_valid  out  1  weights_o holds a complete kernel
weights_o  out  KTAPS*DATA_WIDTH  tap i at [i*DATA_WIDTH +: DATA_WIDTH], row-major (row = i/KSIZE, col = i%KSIZE)
rom_ena  out  1  to ROM ena
rom_addr  out  ADDR_WIDTH  to ROM addra
rom_dout  in  DATA_WIDTH  from ROM douta

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, weights_valid, rom_ena = 0; rom_addr = 0; weights_o = 0; all counters and the valid pipe cleared. Reset asserted mid-load aborts the load immediately; nothing partial is flagged valid.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and kernel_idx < NUM_KERNELS → latch base = BASE_ADDR + kernel_idx*KTAPS (ADDR_WIDTH-bit; no overflow by parameter constraint NUM_KERNELS*KTAPS + BASE_ADDR <= 2^ADDR_WIDTH). Clear weights_valid, set busy, go to ISSUE.
  - start=1 and kernel_idx >= NUM_KERNELS → err=1 for one cycle; stay IDLE; weights_valid and weights_o are unchanged.
- ISSUE: for 25 consecutive cycles, rom_ena=1 and rom_addr=base+n (n=0..24). After n=24, go to DRAIN. rom_ena=0 outside ISSUE; rom_addr holds its last value.
- Timing (start accepted in cycle 0):
  - ISSUE covers cycles 1..25.
  - rom_dout for the address presented in cycle t is valid in cycle t+ROM_LAT.
  - A ROM_LAT-deep shift of rom_ena tags the returned data. Each tagged word is written to tap slot cap_cnt, which increments 0..24.
- DRAIN: wait until cap_cnt has written tap 24 (cycle 25+ROM_LAT), then go to DONE.
- DONE (one cycle, cycle 26+ROM_LAT): done=1, weights_valid=1, busy=0; then IDLE. With ROM_LAT=1, done is in cycle 27.
- weights_valid stays 1 until the next accepted start or reset. weights_o changes only during capture of an accepted load.
- start while busy or in DONE: ignored. It is not queued and does not raise err.
- start held high continuously: a new load is accepted on each return to IDLE. Back-to-back loads are spaced 27+ROM_LAT cycles apart.
- Capture does not depend on tap ordering: slot index comes from cap_cnt, never recomputed from rom_addr.

Decomposition:
- Shared package/header conv_pkg:
  - DATA_WIDTH, ADDR_WIDTH, KSIZE, KTAPS
  - weight-load state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - tap-slice macro/function for weights_o indexing, reused by the MAC array
- One sub-module: weight_rd_valid_pipe. It is a ROM_LAT-deep delay line of rom_ena producing cap_en, with async active-low reset.

Test Plan:
ROM model returns mem[a] = a ^ 16'hA5A5 with ROM_LAT=1 unless noted.
- Reset then idle: rst_n low 3 cycles → all outputs 0; 10 idle cycles keep rom_ena=0 and rom_addr=0.
- Load kernel 0 (start=1, kernel_idx=0, one cycle) → rom_addr 0..24 with rom_ena high in cycles 1..25; done pulse in cycle 27; weights_o tap i = i ^ 16'hA5A5; weights_valid=1.
- Load kernel 92 → base 2300; tap 1 read from address 2301 (= 2301 ^ 16'hA5A5); tap 24 from 2324; busy low in cycle 27.
- kernel_idx=163 → err pulse of 1 cycle, rom_ena never asserted, previous weights_o/weights_valid unchanged; kernel_idx=162 → loads addresses 4050..4074.
- start pulsed at cycle 10 of a load → ignored; exactly 25 reads and one done. rst_n low at cycle 12 → all outputs 0 immediately, weights_valid=0; a following load of kernel 5 completes correctly.
- ROM_LAT=3 build: load kernel 1 → taps from addresses 25..49 in slots 0..24; done in cycle 29.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, weight-load state encoding and tap indexing helper for the
// convolution engine.
package conv_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned KSIZE      = 5;
    localparam int unsigned KTAPS      = KSIZE * KSIZE;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } wl_state_e;

    // Tap i sits at [i*DATA_WIDTH +: DATA_WIDTH], row-major over the kernel.
    function automatic logic [DATA_WIDTH-1:0] tap_slice(
        input logic [KTAPS*DATA_WIDTH-1:0] w,
        input int unsigned                 i
    );
        return w[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/weight_rd_valid_pipe.sv
// Delay line that tags ROM read data: cap_en follows rom_ena by ROM_LAT cycles.
module weight_rd_valid_pipe #(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rom_ena,
    output logic cap_en
);

    logic [ROM_LAT-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rom_ena;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign cap_en = pipe_q[ROM_LAT-1];

endmodule

// File: rtl/weight_load_ctrl.sv
// Loads one 5x5 kernel from the weight ROM into a flat register for the MAC
// array: 25 consecutive reads, latency absorbed by a tagged valid pipe.
module weight_load_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned KSIZE       = 5,
    parameter int unsigned NUM_KERNELS = 163,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned ROM_LAT     = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [7:0]                          kernel_idx,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                weights_valid,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   weights_o,
    output logic                                rom_ena,
    output logic [ADDR_WIDTH-1:0]               rom_addr,
    input  logic [DATA_WIDTH-1:0]               rom_dout
);

    import conv_pkg::*;

    localparam int unsigned   KTAPS    = KSIZE * KSIZE;
    localparam int unsigned   CW       = $clog2(KTAPS + 1);
    localparam logic [CW-1:0] LAST_TAP = CW'(KTAPS - 1);

    wl_state_e             state_q, state_d;
    logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]         cap_cnt_q;
    logic                  cap_en;
    logic                  accept;
    logic                  last_cap;
    logic [ADDR_WIDTH-1:0] base_addr;

    logic                  busy_d, done_d, err_d, valid_d, rom_ena_d;
    logic [ADDR_WIDTH-1:0] rom_addr_d;

    assign accept    = (state_q == StIdle) && start && (32'(kernel_idx) < NUM_KERNELS);
    assign base_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(kernel_idx) * ADDR_WIDTH'(KTAPS);
    assign last_cap  = cap_en && (cap_cnt_q == LAST_TAP);

    weight_rd_valid_pipe #(
        .ROM_LAT (ROM_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rom_ena (rom_ena),
        .cap_en  (cap_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            iss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iss_cnt_d = iss_cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StIssue;
                    iss_cnt_d = '0;
                end
            end
            StIssue: begin
                if (iss_cnt_q == LAST_TAP) begin
                    state_d = StDrain;
                end else begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (last_cap) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        busy_d     = (state_d == StIssue) || (state_d == StDrain);
        done_d     = (state_d == StDone);
        err_d      = (state_q == StIdle) && start && !accept;
        rom_ena_d  = (state_d == StIssue);
        rom_addr_d = rom_addr;
        valid_d    = weights_valid;
        if (accept) begin
            rom_addr_d = base_addr;
            valid_d    = 1'b0;
        end else begin
            if ((state_q == StIssue) && (state_d == StIssue)) begin
                rom_addr_d = rom_addr + 1'b1;
            end
            if (state_d == StDone) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            weights_valid <= 1'b0;
            rom_ena       <= 1'b0;
            rom_addr      <= '0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            weights_valid <= valid_d;
            rom_ena       <= rom_ena_d;
            rom_addr      <= rom_addr_d;
        end
    end

    // Slot comes from the capture count only, never from the read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt_q <= '0;
            weights_o <= '0;
        end else if (accept) begin
            cap_cnt_q <= '0;
        end else if (cap_en) begin
            weights_o[cap_cnt_q*DATA_WIDTH +: DATA_WIDTH] <= rom_dout;
            cap_cnt_q <= cap_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl: one ROM_LAT=1 instance and one ROM_LAT=3
// instance, each with a ROM model returning addr ^ 16'hA5A5.
module tb_weight_load_ctrl;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int WW = 25 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    kernel_idx = '0;
    logic          busy, done, err, weights_valid, rom_ena;
    logic [WW-1:0] weights_o;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout = '0;

    logic          start3 = 1'b0;
    logic [7:0]    kidx3 = '0;
    logic          busy3, done3, err3, valid3, rom_ena3;
    logic [WW-1:0] weights3;
    logic [AW-1:0] rom_addr3;
    logic [DW-1:0] s0 = '0, s1 = '0, s2 = '0;

    int total = 0;
    int bad = 0;

    int r_ena_cnt, r_first, r_last, r_addr_bad, r_done_cyc, r_done_cnt, r_busy_end, r_addr_done;
    logic [WW-1:0] saved;

    always #5 clk = ~clk;

    weight_load_ctrl #(
        .ROM_LAT (1)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .kernel_idx    (kernel_idx),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .weights_valid (weights_valid),
        .weights_o     (weights_o),
        .rom_ena       (rom_ena),
        .rom_addr      (rom_addr),
        .rom_dout      (rom_dout)
    );

    weight_load_ctrl #(
        .ROM_LAT (3)
    ) u_dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start3),
        .kernel_idx    (kidx3),
        .busy          (busy3),
        .done          (done3),
        .err           (err3),
        .weights_valid (valid3),
        .weights_o     (weights3),
        .rom_ena       (rom_ena3),
        .rom_addr      (rom_addr3),
        .rom_dout      (s2)
    );

    always @(posedge clk) begin
        if (rom_ena) rom_dout <= rom_addr ^ 16'hA5A5;
        if (rom_ena3) s0 <= rom_addr3 ^ 16'hA5A5;
        s1 <= s0;
        s2 <= s1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; that cycle is cycle 0 of the load.
    task automatic do_load(input logic [7:0] idx, input int base, input int extra_start);
        r_ena_cnt = 0; r_first = -1; r_last = -1; r_addr_bad = 0;
        r_done_cyc = -1; r_done_cnt = 0; r_busy_end = -1; r_addr_done = -1;
        start = 1'b1;
        kernel_idx = idx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rom_ena) begin
                r_ena_cnt++;
                if (r_first < 0) r_first = c;
                r_last = c;
                if (int'(rom_addr) != base + c - 1) r_addr_bad++;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = c;
                    r_addr_done = int'(rom_addr);
                end
            end
            if (c > 1 && !busy && r_busy_end < 0) r_busy_end = c;
            @(posedge clk);
            #1;
            start = (c + 1 == extra_start);
        end
        start = 1'b0;
    endtask

    task automatic check_taps(input string tag, input int base);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("%s_tap%0d", tag, i), 32'(conv_pkg::tap_slice(weights_o, i)),
                  32'((base + i) ^ 16'hA5A5));
        end
    endtask

    initial begin
        int cnt;
        int d3;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_valid", 32'(weights_valid), 0);
        check("rst_ena", 32'(rom_ena), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_weights", 32'(|weights_o), 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rom_ena || rom_addr != 0) cnt++;
        end
        check("idle_quiet", 32'(cnt), 0);
        @(posedge clk);
        #1;

        // Kernel 0
        do_load(8'd0, 0, -1);
        check("k0_ena_cnt", 32'(r_ena_cnt), 25);
        check("k0_first", 32'(r_first), 1);
        check("k0_last", 32'(r_last), 25);
        check("k0_addr_bad", 32'(r_addr_bad), 0);
        check("k0_done_cyc", 32'(r_done_cyc), 27);
        check("k0_done_cnt", 32'(r_done_cnt), 1);
        check("k0_busy_end", 32'(r_busy_end), 27);
        check("k0_addr_hold", 32'(r_addr_done), 24);
        check("k0_valid", 32'(weights_valid), 1);
        check_taps("k0", 0);

        // Kernel 92
        do_load(8'd92, 2300, -1);
        check("k92_addr_bad", 32'(r_addr_bad), 0);
        check("k92_busy_end", 32'(r_busy_end), 27);
        check("k92_tap1", 32'(conv_pkg::tap_slice(weights_o, 1)), 32'(2301 ^ 16'hA5A5));
        check("k92_tap24", 32'(conv_pkg::tap_slice(weights_o, 24)), 32'(2324 ^ 16'hA5A5));

        // Out-of-range kernel
        saved = weights_o;
        start = 1'b1;
        kernel_idx = 8'd163;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("inv_err_hi", 32'(err), 1);
        cnt = int'(rom_ena);
        @(negedge clk);
        check("inv_err_lo", 32'(err), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rom_ena) cnt++;
        end
        check("inv_no_ena", 32'(cnt), 0);
        check("inv_keep_w", 32'(weights_o == saved), 1);
        check("inv_keep_v", 32'(weights_valid), 1);
        @(posedge clk);
        #1;

        // Last valid kernel
        do_load(8'd162, 4050, -1);
        check("k162_first", 32'(r_first), 1);
        check("k162_last", 32'(r_last), 25);
        check("k162_addr_bad", 32'(r_addr_bad), 0);
        check_taps("k162", 4050);

        // start mid-load is ignored
        do_load(8'd7, 175, 10);
        check("mid_ena_cnt", 32'(r_ena_cnt), 25);
        check("mid_done_cnt", 32'(r_done_cnt), 1);
        check("mid_err", 32'(err), 0);

        // Reset at cycle 12 of a load
        start = 1'b1;
        kernel_idx = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ena", 32'(rom_ena), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_valid", 32'(weights_valid), 0);
        check("arst_addr", 32'(rom_addr), 0);
        check("arst_weights", 32'(|weights_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_load(8'd5, 125, -1);
        check("k5_done_cyc", 32'(r_done_cyc), 27);
        check("k5_valid", 32'(weights_valid), 1);
        check("k5_tap0", 32'(conv_pkg::tap_slice(weights_o, 0)), 32'(125 ^ 16'hA5A5));
        check("k5_tap24", 32'(conv_pkg::tap_slice(weights_o, 24)), 32'(149 ^ 16'hA5A5));

        // ROM_LAT = 3 instance, kernel 1
        start3 = 1'b1;
        kidx3 = 8'd1;
        d3 = -1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done3 && d3 < 0) d3 = c;
            if (rom_ena3) cnt++;
            @(posedge clk);
            #1;
            start3 = 1'b0;
        end
        check("lat3_done_cyc", 32'(d3), 29);
        check("lat3_ena_cnt", 32'(cnt), 25);
        check("lat3_valid", 32'(valid3), 1);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("lat3_tap%0d", i), 32'(conv_pkg::tap_slice(weights3, i)),
                  32'((25 + i) ^ 16'hA5A5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
